// File: rtl/edc_pkg.sv
// Shared SEC-DED definitions: H-matrix data-column generator, mode encodings
// and syndrome classes.
package edc_pkg;

  localparam logic EDC_ENCODE = 1'b0;
  localparam logic EDC_CHECK  = 1'b1;

  typedef enum logic [1:0] {NONE, DATA_SEC, CHK_SEC, DED} edc_syn_class_e;

  // idx-th odd-weight (>= 3) chk_w-bit value, ascending; only used at elaboration.
  function automatic logic [31:0] edc_col(input int unsigned idx, input int unsigned chk_w);
    int unsigned n;
    logic [31:0] res;
    logic        found;
    n     = 0;
    res   = '0;
    found = 1'b0;
    for (int unsigned v = 0; v < (32'd1 << chk_w); v++) begin
      if (!found && ($countones(v) >= 3) && (($countones(v) % 2) == 1)) begin
        if (n == idx) begin
          res   = v;
          found = 1'b1;
        end
        n++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edc_syn_decode.sv
// Combinational syndrome classifier: yields the class of a syndrome and the
// single-bit correction masks for the data and check fields.
module edc_syn_decode
  import edc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHK_W  = 8
) (
  input  logic [CHK_W-1:0]  i_syn,
  output logic [DATA_W-1:0] o_data_mask,
  output logic [CHK_W-1:0]  o_chk_mask,
  output edc_syn_class_e    o_class
);

  logic [DATA_W-1:0] w_match;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_match
    localparam logic [CHK_W-1:0] LP_COL = CHK_W'(edc_col(gi, CHK_W));
    assign w_match[gi] = (i_syn == LP_COL);
  end

  // Data columns are distinct with weight >= 3, so at most one can match.
  always_comb begin
    o_data_mask = '0;
    o_chk_mask  = '0;
    o_class     = NONE;
    if (i_syn == '0) begin
      o_class = NONE;
    end else if (|w_match) begin
      o_class     = DATA_SEC;
      o_data_mask = w_match;
    end else if ($onehot(i_syn)) begin
      o_class    = CHK_SEC;
      o_chk_mask = i_syn;
    end else begin
      o_class = DED;
    end
  end

endmodule

// File: rtl/edc_secded_pipe.sv
// Two-stage SEC-DED encode/check pipeline with valid/ready flow control and
// saturating error statistics. Define EDC_ERR_INJECT_EN to add error injection.
module edc_secded_pipe
  import edc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CHK_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_mode,
  input  logic [DATA_W-1:0]       i_data,
  input  logic [CHK_W-1:0]        i_chk,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [DATA_W-1:0]       o_data,
  output logic [CHK_W-1:0]        o_chk,
  output logic [CHK_W-1:0]        o_syn,
  output logic                    o_err_sec,
  output logic                    o_err_ded,
  input  logic                    i_cnt_clr,
  output logic [CNT_W-1:0]        o_sec_cnt,
  output logic [CNT_W-1:0]        o_ded_cnt,
`ifdef EDC_ERR_INJECT_EN
  input  logic                    i_inj_en,
  input  logic [DATA_W+CHK_W-1:0] i_inj_mask,
`endif
  output logic                    o_ded_sticky
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

  logic [DATA_W-1:0][CHK_W-1:0] w_terms;
  logic [CHK_W-1:0]             w_gen;
  logic [DATA_W-1:0]            w_s1_data_d;
  logic [CHK_W-1:0]             w_s1_chk_d;
  logic [CHK_W-1:0]             w_s1_syn_d;
  logic                         w_s2_load;
  logic                         w_s1_adv;
  logic                         w_out_hs;
  logic [CHK_W-1:0]             w_dec_syn;
  logic [DATA_W-1:0]            w_data_mask;
  logic [CHK_W-1:0]             w_chk_mask;
  edc_syn_class_e               w_class;

  logic                         r_s1_v;
  logic                         r_s1_mode;
  logic [DATA_W-1:0]            r_s1_data;
  logic [CHK_W-1:0]             r_s1_chk;
  logic [CHK_W-1:0]             r_s1_syn;
  logic                         r_s2_v;
  logic [DATA_W-1:0]            r_s2_data;
  logic [CHK_W-1:0]             r_s2_chk;
  logic [CHK_W-1:0]             r_s2_syn;
  logic                         r_s2_sec;
  logic                         r_s2_ded;
  logic [CNT_W-1:0]             r_sec_cnt;
  logic [CNT_W-1:0]             r_ded_cnt;
  logic                         r_ded_sticky;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_col
    localparam logic [CHK_W-1:0] LP_COL = CHK_W'(edc_col(gi, CHK_W));
    assign w_terms[gi] = i_data[gi] ? LP_COL : '0;
  end

  always_comb begin
    w_gen = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_gen = w_gen ^ w_terms[i];
    end
  end

  always_comb begin
    w_s1_data_d = i_data;
    if (i_mode == EDC_CHECK) begin
      w_s1_chk_d = i_chk;
      w_s1_syn_d = w_gen ^ i_chk;
    end else begin
      w_s1_chk_d = w_gen;
      w_s1_syn_d = '0;
    end
`ifdef EDC_ERR_INJECT_EN
    // Injection corrupts the stored codeword only; the syndrome stays clean.
    if ((i_mode == EDC_ENCODE) && i_inj_en) begin
      {w_s1_chk_d, w_s1_data_d} = {w_s1_chk_d, w_s1_data_d} ^ i_inj_mask;
    end
`endif
  end

  assign w_s2_load = !r_s2_v || i_ready;
  assign w_s1_adv  = !r_s1_v || w_s2_load;
  assign o_ready   = w_s1_adv;
  assign w_out_hs  = r_s2_v && i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_v    <= 1'b0;
      r_s1_mode <= EDC_ENCODE;
      r_s1_data <= '0;
      r_s1_chk  <= '0;
      r_s1_syn  <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_mode <= i_mode;
        r_s1_data <= w_s1_data_d;
        r_s1_chk  <= w_s1_chk_d;
        r_s1_syn  <= w_s1_syn_d;
      end
    end
  end

  assign w_dec_syn = (r_s1_mode == EDC_CHECK) ? r_s1_syn : '0;

  edc_syn_decode #(
    .DATA_W (DATA_W),
    .CHK_W  (CHK_W)
  ) u_syn_decode (
    .i_syn       (w_dec_syn),
    .o_data_mask (w_data_mask),
    .o_chk_mask  (w_chk_mask),
    .o_class     (w_class)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_chk  <= '0;
      r_s2_syn  <= '0;
      r_s2_sec  <= 1'b0;
      r_s2_ded  <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_data <= r_s1_data ^ w_data_mask;
        r_s2_chk  <= r_s1_chk ^ w_chk_mask;
        r_s2_syn  <= w_dec_syn;
        r_s2_sec  <= (w_class == DATA_SEC) || (w_class == CHK_SEC);
        r_s2_ded  <= (w_class == DED);
      end
    end
  end

  // Clear wins over a same-cycle event; that event is not counted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sec_cnt    <= '0;
      r_ded_cnt    <= '0;
      r_ded_sticky <= 1'b0;
    end else if (i_cnt_clr) begin
      r_sec_cnt    <= '0;
      r_ded_cnt    <= '0;
      r_ded_sticky <= 1'b0;
    end else begin
      if (w_out_hs && r_s2_sec && (r_sec_cnt != LP_CNT_MAX)) begin
        r_sec_cnt <= r_sec_cnt + 1'b1;
      end
      if (w_out_hs && r_s2_ded && (r_ded_cnt != LP_CNT_MAX)) begin
        r_ded_cnt <= r_ded_cnt + 1'b1;
      end
      if (r_s2_v && r_s2_ded) begin
        r_ded_sticky <= 1'b1;
      end
    end
  end

  assign o_valid      = r_s2_v;
  assign o_data       = r_s2_data;
  assign o_chk        = r_s2_chk;
  assign o_syn        = r_s2_syn;
  assign o_err_sec    = r_s2_sec;
  assign o_err_ded    = r_s2_ded;
  assign o_sec_cnt    = r_sec_cnt;
  assign o_ded_cnt    = r_ded_cnt;
  assign o_ded_sticky = r_ded_sticky;

endmodule

// File: tb/tb_edc_secded_pipe.sv
// Directed bench for edc_secded_pipe; a second narrow-counter instance shares
// all inputs so that counter saturation is reachable in a few cycles.
module tb_edc_secded_pipe;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        ready_up;
  logic        mode;
  logic [31:0] data;
  logic [7:0]  chk;
  logic        ready_dn;
  logic        cnt_clr;

  logic        o_valid;
  logic [31:0] o_data;
  logic [7:0]  o_chk;
  logic [7:0]  o_syn;
  logic        o_err_sec;
  logic        o_err_ded;
  logic [15:0] o_sec_cnt;
  logic [15:0] o_ded_cnt;
  logic        o_ded_sticky;

  logic        s_ready;
  logic        s_valid;
  logic [31:0] s_data;
  logic [7:0]  s_chk;
  logic [7:0]  s_syn;
  logic        s_sec;
  logic        s_ded;
  logic [2:0]  s_sec_cnt;
  logic [2:0]  s_ded_cnt;
  logic        s_sticky;

  int n_total;
  int n_bad;

  edc_secded_pipe #(.DATA_W(32), .CHK_W(8), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .o_ready      (ready_up),
    .i_mode       (mode),
    .i_data       (data),
    .i_chk        (chk),
    .o_valid      (o_valid),
    .i_ready      (ready_dn),
    .o_data       (o_data),
    .o_chk        (o_chk),
    .o_syn        (o_syn),
    .o_err_sec    (o_err_sec),
    .o_err_ded    (o_err_ded),
    .i_cnt_clr    (cnt_clr),
    .o_sec_cnt    (o_sec_cnt),
    .o_ded_cnt    (o_ded_cnt),
    .o_ded_sticky (o_ded_sticky)
  );

  edc_secded_pipe #(.DATA_W(32), .CHK_W(8), .CNT_W(3)) dut_sat (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid),
    .o_ready      (s_ready),
    .i_mode       (mode),
    .i_data       (data),
    .i_chk        (chk),
    .o_valid      (s_valid),
    .i_ready      (ready_dn),
    .o_data       (s_data),
    .o_chk        (s_chk),
    .o_syn        (s_syn),
    .o_err_sec    (s_sec),
    .o_err_ded    (s_ded),
    .i_cnt_clr    (cnt_clr),
    .o_sec_cnt    (s_sec_cnt),
    .o_ded_cnt    (s_ded_cnt),
    .o_ded_sticky (s_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one word with an empty pipeline; returns at the negedge where it is presented.
  task automatic xfer(input logic m, input logic [31:0] d, input logic [7:0] c);
    @(negedge clk);
    valid = 1'b1;
    mode  = m;
    data  = d;
    chk   = c;
    #1;
    check("acc_ready", 64'(ready_up), 64'd1);
    @(negedge clk);
    valid = 1'b0;
    check("lat_s1", 64'(o_valid), 64'd0);
    @(negedge clk);
    check("lat_s2", 64'(o_valid), 64'd1);
  endtask

  logic [31:0] exp_d [4];
  logic [7:0]  exp_c [4];
  int          sent;
  int          got;
  logic        stall_prev;
  logic [31:0] hold_d;
  logic [7:0]  hold_c;

  initial begin
    n_total  = 0;
    n_bad    = 0;
    rst      = 1'b1;
    valid    = 1'b0;
    mode     = 1'b0;
    data     = '0;
    chk      = '0;
    ready_dn = 1'b1;
    cnt_clr  = 1'b0;
    exp_d[0] = 32'h1; exp_c[0] = 8'h07;
    exp_d[1] = 32'h2; exp_c[1] = 8'h0B;
    exp_d[2] = 32'h4; exp_c[2] = 8'h0D;
    exp_d[3] = 32'h8; exp_c[3] = 8'h0E;

    repeat (2) @(negedge clk);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_chk", 64'(o_chk), 64'd0);
    check("rst_sec_cnt", 64'(o_sec_cnt), 64'd0);
    check("rst_ded_cnt", 64'(o_ded_cnt), 64'd0);
    check("rst_sticky", 64'(o_ded_sticky), 64'd0);
    check("rst_ready", 64'(ready_up), 64'd1);
    rst = 1'b0;

    xfer(1'b0, 32'h0000_0001, 8'hFF);
    check("enc1_chk", 64'(o_chk), 64'h07);
    check("enc1_data", 64'(o_data), 64'h1);
    check("enc1_syn", 64'(o_syn), 64'h0);
    check("enc1_flags", 64'({o_err_sec, o_err_ded}), 64'd0);

    xfer(1'b0, 32'h0000_000F, 8'h00);
    check("encF_chk", 64'(o_chk), 64'h0F);

    xfer(1'b1, 32'h0000_0003, 8'h0C);
    check("chk_ok_syn", 64'(o_syn), 64'h0);
    check("chk_ok_flags", 64'({o_err_sec, o_err_ded}), 64'd0);
    check("chk_ok_data", 64'(o_data), 64'h3);
    check("chk_ok_chk", 64'(o_chk), 64'h0C);

    xfer(1'b1, 32'h0000_0002, 8'h0C);
    check("dsec_syn", 64'(o_syn), 64'h07);
    check("dsec_data", 64'(o_data), 64'h3);
    check("dsec_chk", 64'(o_chk), 64'h0C);
    check("dsec_flags", 64'({o_err_sec, o_err_ded}), 64'b10);
    @(negedge clk);
    check("dsec_cnt", 64'(o_sec_cnt), 64'd1);

    xfer(1'b1, 32'h0000_0003, 8'h0D);
    check("csec_syn", 64'(o_syn), 64'h01);
    check("csec_chk", 64'(o_chk), 64'h0C);
    check("csec_data", 64'(o_data), 64'h3);
    check("csec_sec", 64'(o_err_sec), 64'd1);
    @(negedge clk);
    check("csec_cnt", 64'(o_sec_cnt), 64'd2);

    xfer(1'b1, 32'h0000_0000, 8'h0C);
    check("ded_syn", 64'(o_syn), 64'h0C);
    check("ded_flags", 64'({o_err_sec, o_err_ded}), 64'b01);
    check("ded_data", 64'(o_data), 64'h0);
    check("ded_chk", 64'(o_chk), 64'h0C);
    repeat (3) @(negedge clk);
    check("ded_cnt", 64'(o_ded_cnt), 64'd1);
    check("ded_sticky", 64'(o_ded_sticky), 64'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_sticky", 64'(o_ded_sticky), 64'd0);
    check("clr_sec", 64'(o_sec_cnt), 64'd0);
    check("clr_ded", 64'(o_ded_cnt), 64'd0);

    // Clear coincides with the output handshake of a SEC word.
    xfer(1'b1, 32'h0000_0002, 8'h0C);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_prio", 64'(o_sec_cnt), 64'd0);

    // Back-to-back stream with downstream ready 1-0-0-1 while outputs are valid.
    sent       = 0;
    got        = 0;
    stall_prev = 1'b0;
    hold_d     = '0;
    hold_c     = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_valid", 64'(o_valid), 64'd1);
        check("stall_data", 64'(o_data), 64'(hold_d));
        check("stall_chk", 64'(o_chk), 64'(hold_c));
      end
      ready_dn = !(c == 3 || c == 4);
      if (sent < 4) begin
        valid = 1'b1;
        mode  = 1'b0;
        data  = exp_d[sent];
      end else begin
        valid = 1'b0;
      end
      #1;
      if (valid && ready_up) sent++;
      if (o_valid && ready_dn) begin
        if (got < 4) begin
          check("strm_data", 64'(o_data), 64'(exp_d[got]));
          check("strm_chk", 64'(o_chk), 64'(exp_c[got]));
        end
        got++;
      end
      stall_prev = o_valid && !ready_dn;
      hold_d     = o_data;
      hold_c     = o_chk;
    end
    valid    = 1'b0;
    ready_dn = 1'b1;
    check("strm_sent", 64'(sent), 64'd4);
    check("strm_got", 64'(got), 64'd4);

    // Saturation: 10 SEC then 9 DED words; the 3-bit instance pins at 7.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      valid = 1'b1;
      mode  = 1'b1;
      data  = 32'h2;
      chk   = 8'h0C;
    end
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      data = 32'h0;
    end
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_sec_main", 64'(o_sec_cnt), 64'd10);
    check("sat_ded_main", 64'(o_ded_cnt), 64'd9);
    check("sat_sec_narrow", 64'(s_sec_cnt), 64'd7);
    check("sat_ded_narrow", 64'(s_ded_cnt), 64'd7);

    // Asynchronous reset in the middle of a stream.
    @(negedge clk);
    valid = 1'b1;
    mode  = 1'b0;
    data  = 32'h10;
    repeat (2) @(negedge clk);
    check("mid_valid_pre", 64'(o_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid_rst", 64'(o_valid), 64'd0);
    check("mid_data_rst", 64'(o_data), 64'd0);
    check("mid_sec_rst", 64'(o_sec_cnt), 64'd0);
    check("mid_sticky_rst", 64'(o_ded_sticky), 64'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_drop", 64'(o_valid), 64'd0);
    end
    xfer(1'b0, 32'h0000_0010, 8'h00);
    check("post_rst_chk", 64'(o_chk), 64'h13);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
